logic_op_decoder: RTL and testbench
===================================

LOGIC_OP_DECODER -- requirements
Module: logic_op_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand/result bit width (>=1).
REQ-002 SHALL have parameter NSAMP, default 4, number of samples per decode burst (>=1).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  begin a decode burst (sampled in IDLE only).
REQ-006 SHALL have port in_valid_i  input  1  sample present on data0_i/data1_i/result_i.
REQ-007 SHALL have port in_ready_o  output  1  decoder accepts a sample this cycle.
REQ-008 SHALL have port data0_i  input  WIDTH  first operand of observed sample.
REQ-009 SHALL have port data1_i  input  WIDTH  second operand of observed sample.
REQ-010 SHALL have port result_i  input  WIDTH  observed logic-unit result.
REQ-011 SHALL have port out_valid_o  output  1  decode report valid.
REQ-012 SHALL have port out_ready_i  input  1  consumer accepts report.
REQ-013 SHALL have port match_mask_o  output  4  bit k set = op code k consistent with every accepted sample.
REQ-014 SHALL have port sel_o  output  2  lowest-index set bit of match_mask_o; 2'b00 when mask is zero.
REQ-015 SHALL have port unique_o  output  1  exactly one bit of match_mask_o set.
REQ-016 SHALL have port busy_o  output  1  state is not IDLE.

Function
REQ-017 SHALL define op codes: 00 -> all-zero, 01 -> data0 AND data1, 10 -> data0 OR data1, 11 -> data0 XNOR data1 (bitwise, WIDTH bits).
REQ-018 SHALL implement FSM states IDLE, COLLECT, REPORT.
REQ-019 SHALL in IDLE: in_ready_o=0, out_valid_o=0; start_i=1 -> COLLECT, mask loaded 4'b1111, sample count cleared.
REQ-020 SHALL in COLLECT: in_ready_o=1; a sample is accepted when in_valid_i && in_ready_o.
REQ-021 SHALL on each accepted sample clear mask bit k when op k's result != result_i, and increment the count.
REQ-022 SHALL leave COLLECT for REPORT on the cycle after the NSAMP-th accept, or after any accept that leaves the updated mask all-zero (early exit).
REQ-023 SHALL hold mask and count unchanged in COLLECT cycles with in_valid_i=0.
REQ-024 SHALL in REPORT: out_valid_o=1, in_ready_o=0; match_mask_o/sel_o/unique_o stable until handshake.
REQ-025 SHALL on out_valid_o && out_ready_i return to IDLE next cycle.
REQ-026 SHALL ignore start_i in COLLECT and REPORT.
REQ-027 SHALL drive match_mask_o, sel_o, unique_o combinationally from the registered mask in all states.
REQ-028 SHALL size the sample counter to hold 0..NSAMP without wrap.
REQ-029 SHALL add exactly one cycle of latency from final accept to out_valid_o=1.

Reset
REQ-030 SHALL on rst_ni=0, at any time including mid-burst, immediately enter IDLE and clear the count.
REQ-031 SHALL reset outputs: in_ready_o=0, out_valid_o=0, busy_o=0, match_mask_o=4'b0000, sel_o=2'b00, unique_o=0.
REQ-032 SHALL discard a partially collected burst on reset; no report is produced for it.

Verification (WIDTH=3, NSAMP=4)
REQ-033 SHALL cover ambiguity then resolution: start; samples (101,011,001), (110,010,010), then two more AND-consistent samples -> after sample 1 mask 1010; final mask 0010, sel_o=01, unique_o=1, out_valid_o one cycle after 4th accept.
REQ-034 SHALL cover OR: four samples with (101,011,111) -> mask 0100, sel_o=10, unique_o=1.
REQ-035 SHALL cover all-zero operands: four samples (000,000,000) -> mask 0111, sel_o=00, unique_o=0.
REQ-036 SHALL cover early exit: sample (101,011,100) -> mask 0000 after 1 accept, REPORT with sel_o=00, unique_o=0, no further accepts.
REQ-037 SHALL cover backpressure/gaps: in_valid_i toggling in COLLECT and out_ready_i=0 for 5 cycles in REPORT -> count advances only on accepts; outputs held stable until out_ready_i=1.
REQ-038 SHALL cover reset mid-burst: rst_ni low after 2 accepts -> all outputs at reset values asynchronously; next start begins with mask 1111 and count 0.

Source files
------------

// File: rtl/logic_op_decoder.sv
// Observes samples from a 2-bit-opcode logic unit and narrows down which op codes
// are consistent with every accepted (data0, data1, result) triple in a burst.
module logic_op_decoder #(
  parameter int WIDTH = 3,
  parameter int NSAMP = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       match_mask_o,
  output logic [1:0]       sel_o,
  output logic             unique_o,
  output logic             busy_o
);

  localparam int CW = $clog2(NSAMP + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_REPORT  = 2'b10
  } state_t;

  state_t          r_state;
  logic [3:0]      r_mask;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic            w_accept;
  logic [3:0]      w_mask_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_done;

  // Bit k set when op code k reproduces the observed result for these operands.
  function automatic logic [3:0] f_match(input logic [WIDTH-1:0] d0,
                                         input logic [WIDTH-1:0] d1,
                                         input logic [WIDTH-1:0] res);
    logic [3:0] m;
    m[0] = (res == {WIDTH{1'b0}});
    m[1] = (res == (d0 & d1));
    m[2] = (res == (d0 | d1));
    m[3] = (res == ~(d0 ^ d1));
    return m;
  endfunction

  // Next mask/count for an accepted sample and the burst-complete condition.
  always_comb begin
    w_accept    = in_valid_i && r_in_ready;
    w_mask_next = r_mask & f_match(data0_i, data1_i, result_i);
    w_cnt_next  = r_cnt + CW'(1);
    if ((w_cnt_next == CW'(NSAMP)) || (w_mask_next == 4'b0000)) begin
      w_done = 1'b1;
    end else begin
      w_done = 1'b0;
    end
  end

  // Report fields decoded from the registered mask.
  always_comb begin
    match_mask_o = r_mask;
    if (r_mask[0]) begin
      sel_o = 2'b00;
    end else if (r_mask[1]) begin
      sel_o = 2'b01;
    end else if (r_mask[2]) begin
      sel_o = 2'b10;
    end else if (r_mask[3]) begin
      sel_o = 2'b11;
    end else begin
      sel_o = 2'b00;
    end
    unique_o = (r_mask != 4'b0000) && ((r_mask & (r_mask - 4'b0001)) == 4'b0000);
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;

  // Burst FSM; handshake and busy flags are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_mask      <= 4'b0000;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state    <= ST_COLLECT;
            r_mask     <= 4'b1111;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (w_accept) begin
            r_mask <= w_mask_next;
            r_cnt  <= w_cnt_next;
            if (w_done) begin
              r_state     <= ST_REPORT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_REPORT: begin
          if (out_ready_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mask      <= 4'b0000;
          r_cnt       <= '0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_decoder.sv
// Directed bench for logic_op_decoder (WIDTH=3, NSAMP=4): per-sample vector table
// plus hand-written backpressure and mid-burst reset sequences.
module tb_logic_op_decoder;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [2:0] data0_i;
  logic [2:0] data1_i;
  logic [2:0] result_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [3:0] match_mask_o;
  logic [1:0] sel_o;
  logic       unique_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic_op_decoder #(.WIDTH(3), .NSAMP(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .data0_i      (data0_i),
    .data1_i      (data1_i),
    .result_i     (result_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .match_mask_o (match_mask_o),
    .sel_o        (sel_o),
    .unique_o     (unique_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       first;
    logic [2:0] d0;
    logic [2:0] d1;
    logic [2:0] res;
    logic [3:0] mask;
    logic       rep;
    logic [1:0] sel;
    logic       uniq;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_busy", {7'd0, busy_o}, 8'd1);
    chk("start_ready", {7'd0, in_ready_o}, 8'd1);
    chk("start_mask", {4'd0, match_mask_o}, 8'hF);
  endtask

  task automatic send(input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] res);
    in_valid_i = 1'b1;
    data0_i    = d0;
    data1_i    = d1;
    result_i   = res;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_in_ready"}, {7'd0, in_ready_o}, 8'd0);
    chk({nm, "_out_valid"}, {7'd0, out_valid_o}, 8'd0);
    chk({nm, "_busy"}, {7'd0, busy_o}, 8'd0);
    chk({nm, "_mask"}, {4'd0, match_mask_o}, 8'h0);
    chk({nm, "_sel"}, {6'd0, sel_o}, 8'd0);
    chk({nm, "_unique"}, {7'd0, unique_o}, 8'd0);
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("hs_out_valid", {7'd0, out_valid_o}, 8'd0);
    chk("hs_busy", {7'd0, busy_o}, 8'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'b101, 3'b011, 3'b001, 4'b1010, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 3'b110, 3'b010, 3'b010, 4'b0010, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 3'b111, 3'b101, 3'b101, 4'b0010, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 3'b011, 3'b110, 3'b010, 4'b0010, 1'b1, 2'b01, 1'b1};
    vecs[4]  = '{1'b1, 3'b101, 3'b011, 3'b111, 4'b0100, 1'b0, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 3'b101, 3'b011, 3'b111, 4'b0100, 1'b0, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 3'b101, 3'b011, 3'b111, 4'b0100, 1'b0, 2'b00, 1'b0};
    vecs[7]  = '{1'b0, 3'b101, 3'b011, 3'b111, 4'b0100, 1'b1, 2'b10, 1'b1};
    vecs[8]  = '{1'b1, 3'b000, 3'b000, 3'b000, 4'b0111, 1'b0, 2'b00, 1'b0};
    vecs[9]  = '{1'b0, 3'b000, 3'b000, 3'b000, 4'b0111, 1'b0, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 3'b000, 3'b000, 3'b000, 4'b0111, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 3'b000, 3'b000, 3'b000, 4'b0111, 1'b1, 2'b00, 1'b0};
    vecs[12] = '{1'b1, 3'b101, 3'b011, 3'b100, 4'b0000, 1'b1, 2'b00, 1'b0};

    rst_ni      = 1'b0;
    start_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    data0_i     = 3'b000;
    data1_i     = 3'b000;
    result_i    = 3'b000;
    tick();
    chk_reset_outs("por");
    rst_ni = 1'b1;
    tick();
    chk_reset_outs("idle");

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].first) do_start();
      send(vecs[i].d0, vecs[i].d1, vecs[i].res);
      chk($sformatf("v%0d_mask", i), {4'd0, match_mask_o}, {4'd0, vecs[i].mask});
      chk($sformatf("v%0d_out_valid", i), {7'd0, out_valid_o}, {7'd0, vecs[i].rep});
      chk($sformatf("v%0d_in_ready", i), {7'd0, in_ready_o}, {7'd0, ~vecs[i].rep});
      if (vecs[i].rep) begin
        chk($sformatf("v%0d_sel", i), {6'd0, sel_o}, {6'd0, vecs[i].sel});
        chk($sformatf("v%0d_unique", i), {7'd0, unique_o}, {7'd0, vecs[i].uniq});
        if (i == 12) begin
          // A sample offered during REPORT must not be accepted.
          send(3'b000, 3'b000, 3'b000);
          chk("early_no_accept_mask", {4'd0, match_mask_o}, 8'h0);
          chk("early_still_valid", {7'd0, out_valid_o}, 8'd1);
        end
        handshake();
      end
    end

    // Gaps in COLLECT (with start_i held high) and backpressure in REPORT.
    do_start();
    start_i = 1'b1;
    data0_i = 3'b101; data1_i = 3'b011; result_i = 3'b100;
    tick(); tick();
    chk("gap_mask_hold", {4'd0, match_mask_o}, 8'hF);
    for (int k = 0; k < 4; k++) begin
      send(3'b101, 3'b011, 3'b111);
      data0_i = 3'b101; data1_i = 3'b011; result_i = 3'b100;
      if (k < 3) begin
        chk($sformatf("gap_no_report_%0d", k), {7'd0, out_valid_o}, 8'd0);
        tick();
        chk($sformatf("gap_idle_cycle_%0d", k), {7'd0, out_valid_o}, 8'd0);
      end
    end
    start_i = 1'b0;
    chk("gap_report", {7'd0, out_valid_o}, 8'd1);
    for (int k = 0; k < 5; k++) begin
      data0_i = 3'(k);
      tick();
      chk($sformatf("bp_valid_%0d", k), {7'd0, out_valid_o}, 8'd1);
      chk($sformatf("bp_mask_%0d", k), {4'd0, match_mask_o}, 8'h4);
      chk($sformatf("bp_sel_%0d", k), {6'd0, sel_o}, 8'd2);
      chk($sformatf("bp_unique_%0d", k), {7'd0, unique_o}, 8'd1);
    end
    handshake();

    // Asynchronous reset after two accepts, away from any clock edge.
    do_start();
    send(3'b101, 3'b011, 3'b001);
    send(3'b110, 3'b010, 3'b010);
    chk("mid_mask", {4'd0, match_mask_o}, 8'h2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    tick();
    chk_reset_outs("rst_held");
    rst_ni = 1'b1;
    tick();
    chk("no_stale_report", {7'd0, out_valid_o}, 8'd0);
    do_start();
    for (int k = 0; k < 4; k++) begin
      send(3'b000, 3'b000, 3'b000);
      chk($sformatf("post_rst_valid_%0d", k), {7'd0, out_valid_o}, {7'd0, (k == 3) ? 1'b1 : 1'b0});
    end
    chk("post_rst_mask", {4'd0, match_mask_o}, 8'h7);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
